// File: rtl/music_pkg.sv
// Shared constants and types for the music sequencer: tone width, the silence
// tone, and the song-level state encoding.
package music_pkg;

  localparam int TONE_W = 32;

  // A tone above the audible range, which the note generator treats as silence.
  localparam logic [TONE_W-1:0] NM0 = 32'd20000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } song_state_t;

endpackage

// File: rtl/music_sequencer_if.sv
// Bundle between game control / tone ROMs (master side) and the sequencer (slave side).
interface music_sequencer_if #(
  parameter int BEAT_W = 9
);
  // start, stop and sfx_req are single-cycle pulses sampled on every clock edge;
  // no ready handshake, so the sequencer acts on them in the cycle they are seen.
  logic                      start;
  logic                      stop;
  logic                      pause;
  logic                      loop_en;
  logic                      sfx_req;
  logic [1:0]                sfx_id;
  logic [music_pkg::TONE_W-1:0] bgm_tone;
  logic [music_pkg::TONE_W-1:0] sfx_tone;

  logic [BEAT_W-1:0]         beat_num;
  logic [1:0]                sfx_sel;
  logic [3:0]                sfx_beat;
  logic [music_pkg::TONE_W-1:0] tone_out;
  logic                      playing;
  logic                      song_done;
  music_pkg::song_state_t    state;

  modport master (
    output start, stop, pause, loop_en, sfx_req, sfx_id, bgm_tone, sfx_tone,
    input  beat_num, sfx_sel, sfx_beat, tone_out, playing, song_done, state
  );

  modport slave (
    input  start, stop, pause, loop_en, sfx_req, sfx_id, bgm_tone, sfx_tone,
    output beat_num, sfx_sel, sfx_beat, tone_out, playing, song_done, state
  );

endinterface

// File: rtl/music_sequencer_beat_tick_gen.sv
// Quarter-beat divider: counts 0..DIV-1 while running and flags the last count.
// When not running it either holds its count or returns to zero.
module beat_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clear_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = run_i & (cnt_q == LAST);

endmodule

// File: rtl/music_sequencer.sv
// Background-music beat sequencer with a priority sound-effect overlay, producing
// one registered tone for the square-wave generator.
module music_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int BEATS_PER_SEC = 8,
  parameter int BEAT_W        = 9,
  parameter int SONG_LEN      = 350,
  parameter int SFX_LEN       = 8
) (
  input logic            clk,
  input logic            rst_n,
  music_sequencer_if.slave bus
);

  localparam int DIV = CLK_HZ / BEATS_PER_SEC;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SONG_LEN - 1);
  localparam logic [3:0]        LAST_SFX  = 4'(SFX_LEN - 1);

  song_state_t       state_q;
  logic [BEAT_W-1:0] beat_q;
  logic              done_q;
  logic              sfx_act_q;
  logic [1:0]        sfx_sel_q;
  logic [3:0]        sfx_beat_q;
  logic [TONE_W-1:0] tone_q, tone_d;

  logic tick;
  logic div_run, div_clear, div_hold;

  // The divider is shared by song and SFX; a new SFX or a (re)start realigns it.
  assign div_run   = (state_q == PLAY) | sfx_act_q;
  assign div_clear = bus.sfx_req | (bus.start & ~bus.stop);
  assign div_hold  = (state_q == PAUSE);

  beat_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (div_run),
    .clear_i (div_clear),
    .hold_i  (div_hold),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state_q <= IDLE;
        beat_q  <= '0;
      end else if (bus.start) begin
        state_q <= PLAY;
        beat_q  <= '0;
      end else begin
        case (state_q)
          PLAY: begin
            if (tick && beat_q == LAST_BEAT) begin
              beat_q <= '0;
              if (!bus.loop_en) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else if (bus.pause) begin
                state_q <= PAUSE;
              end
            end else begin
              if (tick) beat_q <= beat_q + BEAT_W'(1);
              if (bus.pause) state_q <= PAUSE;
            end
          end
          PAUSE: begin
            if (!bus.pause) state_q <= PLAY;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // SFX keeps running across song stop; only reset cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sfx_act_q  <= 1'b0;
      sfx_sel_q  <= '0;
      sfx_beat_q <= '0;
    end else if (bus.sfx_req) begin
      sfx_act_q  <= 1'b1;
      sfx_sel_q  <= bus.sfx_id;
      sfx_beat_q <= '0;
    end else if (sfx_act_q && tick) begin
      if (sfx_beat_q == LAST_SFX) begin
        sfx_act_q  <= 1'b0;
        sfx_beat_q <= '0;
      end else begin
        sfx_beat_q <= sfx_beat_q + 4'd1;
      end
    end
  end

  always_comb begin
    tone_d = NM0;
    if (sfx_act_q) begin
      tone_d = bus.sfx_tone;
    end else if (state_q == PLAY) begin
      tone_d = bus.bgm_tone;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_q <= NM0;
    end else begin
      tone_q <= tone_d;
    end
  end

  assign bus.beat_num  = beat_q;
  assign bus.sfx_sel   = sfx_sel_q;
  assign bus.sfx_beat  = sfx_beat_q;
  assign bus.tone_out  = tone_q;
  assign bus.playing   = (state_q != IDLE);
  assign bus.song_done = done_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: scripted vectors, corner-case sequences and random
// stimulus, all checked every cycle against a behavioural model of the sequencer.
module tb_music_sequencer;
  import music_pkg::*;

  localparam int CLK_HZ   = 16;
  localparam int BPS      = 4;
  localparam int DIV      = CLK_HZ / BPS;
  localparam int BEAT_W   = 3;
  localparam int SONG_LEN = 6;
  localparam int SFX_LEN  = 3;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  music_sequencer_if #(.BEAT_W(BEAT_W)) bus();

  music_sequencer #(
    .CLK_HZ(CLK_HZ), .BEATS_PER_SEC(BPS), .BEAT_W(BEAT_W),
    .SONG_LEN(SONG_LEN), .SFX_LEN(SFX_LEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- tone ROMs ----------------
  function automatic logic [31:0] bgm_rom(int b);
    return 32'(1000 + b * 10);
  endfunction

  function automatic logic [31:0] sfx_rom(int s, int b);
    return 32'(5000 + s * 100 + b);
  endfunction

  always_comb begin
    bus.bgm_tone = bgm_rom(int'(bus.beat_num));
    bus.sfx_tone = sfx_rom(int'(bus.sfx_sel), int'(bus.sfx_beat));
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          on;     // song started and not ended/stopped
    bit          fr;     // song frozen by pause
    int          pos;    // song quarter-beat
    int          dv;     // divider phase
    int          left;   // SFX quarter-beats still to play (0 = none)
    int          sel;
    logic [31:0] tone;
    bit          done;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, bit start, bit stop, bit pause,
                                        bit loop_en, bit req, int id);
    model_t n = c;
    bit running = (c.on && !c.fr) || c.left > 0;
    bit tick    = running && c.dv == DIV - 1;
    n.done = 1'b0;
    if (c.left > 0)          n.tone = sfx_rom(c.sel, SFX_LEN - c.left);
    else if (c.on && !c.fr)  n.tone = bgm_rom(c.pos);
    else                     n.tone = NM0;

    if (req || (start && !stop)) n.dv = 0;
    else if (running)            n.dv = (c.dv + 1) % DIV;
    else if (!c.on)              n.dv = 0;

    if (stop) begin
      n.on = 0; n.fr = 0; n.pos = 0;
    end else if (start) begin
      n.on = 1; n.fr = 0; n.pos = 0;
    end else if (c.on && !c.fr) begin
      if (tick) begin
        n.pos = c.pos + 1;
        if (n.pos == SONG_LEN) begin
          n.pos = 0;
          if (!loop_en) begin n.on = 0; n.done = 1; end
        end
      end
      if (n.on && pause) n.fr = 1;
    end else if (c.on && c.fr && !pause) begin
      n.fr = 0;
    end

    if (req) begin
      n.left = SFX_LEN; n.sel = id;
    end else if (c.left > 0 && tick) begin
      n.left = c.left - 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{on: 0, fr: 0, pos: 0, dv: 0, left: 0, sel: 0, tone: NM0, done: 0};
    end else begin
      m <= model_next(m, bus.start, bus.stop, bus.pause, bus.loop_en,
                      bus.sfx_req, int'(bus.sfx_id));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("beat_num",  32'(bus.beat_num),  32'(m.pos));
      check("playing",   32'(bus.playing),   32'(m.on));
      check("song_done", 32'(bus.song_done), 32'(m.done));
      check("tone_out",  bus.tone_out,       m.tone);
      check("sfx_sel",   32'(bus.sfx_sel),   32'(m.sel));
      check("sfx_beat",  32'(bus.sfx_beat),  32'(m.left > 0 ? SFX_LEN - m.left : 0));
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    bit start; bit stop; bit pause; bit loop_en; bit req;
    int id; int cycles; int exp_beat; bit exp_play;
  } vec_t;

  vec_t vecs[17];

  task automatic apply_vec(vec_t v, int idx);
    bus.start   = v.start;
    bus.stop    = v.stop;
    bus.pause   = v.pause;
    bus.loop_en = v.loop_en;
    bus.sfx_req = v.req;
    bus.sfx_id  = 2'(v.id);
    for (int i = 0; i < v.cycles; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.sfx_req = 1'b0;
      end
    end
    check($sformatf("vec%0d_beat", idx), 32'(bus.beat_num), 32'(v.exp_beat));
    check($sformatf("vec%0d_playing", idx), 32'(bus.playing), 32'(v.exp_play));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_beat"},     32'(bus.beat_num),  32'd0);
    check({tag, "_sfx_sel"},  32'(bus.sfx_sel),   32'd0);
    check({tag, "_sfx_beat"}, 32'(bus.sfx_beat),  32'd0);
    check({tag, "_tone"},     bus.tone_out,       NM0);
    check({tag, "_playing"},  32'(bus.playing),   32'd0);
    check({tag, "_done"},     32'(bus.song_done), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int done_cnt;

    //            start stop pause loop req id cyc beat play
    vecs[0]  = '{1, 0, 0, 0, 0, 0,  1, 0, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 0,  4, 1, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0,  4, 2, 1};
    vecs[3]  = '{0, 0, 1, 0, 0, 0, 20, 2, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0,  2, 2, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 0,  2, 3, 1};
    vecs[6]  = '{0, 0, 0, 1, 0, 0,  8, 5, 1};
    vecs[7]  = '{0, 0, 0, 1, 0, 0,  4, 0, 1};
    vecs[8]  = '{0, 0, 0, 1, 0, 0,  4, 1, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 16, 5, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 0,  4, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 0, 0,  5, 1, 1};
    vecs[12] = '{1, 1, 0, 0, 0, 0,  1, 0, 0};
    vecs[13] = '{0, 1, 0, 0, 0, 0,  3, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 0,  1, 0, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 0,  4, 1, 1};
    vecs[16] = '{0, 0, 0, 0, 1, 3, 13, 4, 1};

    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.loop_en = 0;
    bus.sfx_req = 0; bus.sfx_id = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) apply_vec(vecs[i], i);

    // Non-looping song end: exactly one song_done pulse, then silence.
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.song_done) done_cnt++;
    end
    check("end_done_count", 32'(done_cnt), 32'd1);
    check("end_playing", 32'(bus.playing), 32'd0);
    check("end_tone", bus.tone_out, NM0);

    // Looping song never reports done.
    bus.loop_en = 1'b1;
    pulse_start();
    done_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.song_done) done_cnt++;
    end
    check("loop_done_count", 32'(done_cnt), 32'd0);
    check("loop_playing", 32'(bus.playing), 32'd1);

    // Asynchronous reset while an SFX plays: outputs clear without a clock edge.
    bus.sfx_id  = 2'd2;
    bus.sfx_req = 1'b1;
    @(negedge clk);
    bus.sfx_req = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_sfx_sel", 32'(bus.sfx_sel), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.loop_en = 1'b0;

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.start   = ($urandom_range(0, 59) == 0) || (!m.on && $urandom_range(0, 9) == 0);
      bus.stop    = ($urandom_range(0, 149) == 0);
      bus.sfx_req = ($urandom_range(0, 39) == 0);
      bus.sfx_id  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)  bus.pause   = ~bus.pause;
      if ($urandom_range(0, 199) == 0) bus.loop_en = ~bus.loop_en;
    end
    @(negedge clk);
    bus.start = 0; bus.stop = 0; bus.sfx_req = 0; bus.pause = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
